// File: rtl/cpu_irq_sched.sv
// Interrupt and reset scheduler for the three Z80 cores: misc-control latch,
// per-frame IRQs for CPU0/CPU1, twice-per-frame NMI for CPU2, sub-CPU reset sequencing.
module cpu_irq_sched #(
    parameter int IRQ_LINE  = 224,
    parameter int NMI_LINE0 = 64,
    parameter int NMI_LINE1 = 192,
    parameter int NMI_WIDTH = 32,
    parameter int RST_HOLD  = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LINE_STB,
    input  logic [8:0] VPOS,
    input  logic       PAUSE,
    input  logic       LWR,
    input  logic [2:0] LAD,
    input  logic       LDI,
    input  logic       ACK0,
    input  logic       ACK1,
    input  logic       NMIACK2,
    output logic       IRQ0,
    output logic       IRQ1,
    output logic       NMI2,
    output logic       RSTSUB,
    output logic [7:0] LATCH
);

    typedef enum logic {N_IDLE, N_PULSE} nmi_state_t;
    typedef enum logic [1:0] {S_HOLD, S_REL_WAIT, S_RUN} sub_state_t;

    logic [7:0] latch_q, latch_d;
    logic       pirq_q, pirq_d, pnmi_q, pnmi_d;
    logic       irq0_q, irq0_d, irq1_q, irq1_d;
    logic       rstsub_q, rstsub_d;
    nmi_state_t nst_q, nst_d;
    sub_state_t sub_q, sub_d;
    logic [7:0] ncnt_q, ncnt_d, scnt_q, scnt_d;

    logic raw_irq, raw_nmi, ev_irq, ev_nmi, nmi_set;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            latch_q  <= 8'h00;
            pirq_q   <= 1'b0;
            pnmi_q   <= 1'b0;
            irq0_q   <= 1'b0;
            irq1_q   <= 1'b0;
            rstsub_q <= 1'b1;
            nst_q    <= N_IDLE;
            sub_q    <= S_HOLD;
            ncnt_q   <= 8'd0;
            scnt_q   <= 8'd0;
        end else begin
            latch_q  <= latch_d;
            pirq_q   <= pirq_d;
            pnmi_q   <= pnmi_d;
            irq0_q   <= irq0_d;
            irq1_q   <= irq1_d;
            rstsub_q <= rstsub_d;
            nst_q    <= nst_d;
            sub_q    <= sub_d;
            ncnt_q   <= ncnt_d;
            scnt_q   <= scnt_d;
        end
    end

    always_comb begin
        latch_d = latch_q;
        if (LWR) latch_d[LAD] = LDI;

        raw_irq = LINE_STB && (VPOS == 9'(IRQ_LINE));
        raw_nmi = LINE_STB && ((VPOS == 9'(NMI_LINE0)) || (VPOS == 9'(NMI_LINE1)));

        // Events seen during PAUSE collapse into one pending flag each.
        pirq_d = PAUSE ? (pirq_q || raw_irq) : 1'b0;
        pnmi_d = PAUSE ? (pnmi_q || raw_nmi) : 1'b0;
        ev_irq = !PAUSE && (raw_irq || pirq_q);
        ev_nmi = !PAUSE && (raw_nmi || pnmi_q);

        sub_d  = sub_q;
        scnt_d = scnt_q;
        case (sub_q)
            S_HOLD: if (latch_d[3]) begin
                sub_d  = S_REL_WAIT;
                scnt_d = 8'(RST_HOLD);
            end
            S_REL_WAIT: begin
                if (!latch_d[3])         sub_d = S_HOLD;
                else if (scnt_q == 8'd0) sub_d = S_RUN;
                else                     scnt_d = scnt_q - 8'd1;
            end
            S_RUN:   if (!latch_d[3]) sub_d = S_HOLD;
            default: sub_d = S_HOLD;
        endcase
        rstsub_d = (sub_d != S_RUN);

        // Set uses the pre-write latch; clears track the latch as it is written.
        if (ev_irq && latch_q[0])        irq0_d = 1'b1;
        else if (ACK0 || !latch_d[0])    irq0_d = 1'b0;
        else                             irq0_d = irq0_q;

        if (ev_irq && latch_q[1])        irq1_d = 1'b1;
        else if (ACK1 || !latch_d[1])    irq1_d = 1'b0;
        else                             irq1_d = irq1_q;
        if (rstsub_d) irq1_d = 1'b0;

        nmi_set = ev_nmi && !latch_q[2] && !rstsub_d;
        nst_d   = nst_q;
        ncnt_d  = ncnt_q;
        case (nst_q)
            N_IDLE: if (nmi_set) begin
                nst_d  = N_PULSE;
                ncnt_d = 8'(NMI_WIDTH - 1);
            end
            N_PULSE: begin
                if (nmi_set)
                    ncnt_d = 8'(NMI_WIDTH - 1);
                else if (ncnt_q == 8'd0 || NMIACK2 || latch_d[2] || rstsub_d)
                    nst_d = N_IDLE;
                else
                    ncnt_d = ncnt_q - 8'd1;
            end
            default: nst_d = N_IDLE;
        endcase
    end

    assign IRQ0   = irq0_q;
    assign IRQ1   = irq1_q;
    assign NMI2   = (nst_q == N_PULSE);
    assign RSTSUB = rstsub_q;
    assign LATCH  = latch_q;

endmodule

// File: tb/tb_cpu_irq_sched.sv
// Self-checking bench for cpu_irq_sched: latch/IRQ0 vector table through a
// scoreboard queue, then hand-written release, NMI, pause and reset sequences.
module tb_cpu_irq_sched;

    logic       CLK, RST, LINE_STB, PAUSE, LWR, LDI, ACK0, ACK1, NMIACK2;
    logic [8:0] VPOS;
    logic [2:0] LAD;
    logic       IRQ0, IRQ1, NMI2, RSTSUB;
    logic [7:0] LATCH;

    int n_chk = 0;
    int n_pass = 0;

    cpu_irq_sched dut (
        .CLK(CLK), .RST(RST), .LINE_STB(LINE_STB), .VPOS(VPOS), .PAUSE(PAUSE),
        .LWR(LWR), .LAD(LAD), .LDI(LDI), .ACK0(ACK0), .ACK1(ACK1), .NMIACK2(NMIACK2),
        .IRQ0(IRQ0), .IRQ1(IRQ1), .NMI2(NMI2), .RSTSUB(RSTSUB), .LATCH(LATCH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       lwr;
        logic [2:0] lad;
        logic       ldi;
        logic       stb;
        logic [8:0] vpos;
        logic       ack0;
        logic       e_irq0;
        logic [7:0] e_latch;
        logic       e_rst;
    } vec_t;

    vec_t tbl [15];
    vec_t sb_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic d);
        LWR = 1'b1; LAD = a; LDI = d;
        cyc();
        LWR = 1'b0;
    endtask

    task automatic stb(input int v);
        LINE_STB = 1'b1; VPOS = 9'(v);
        cyc();
        LINE_STB = 1'b0;
    endtask

    // Cycles until the signal drops, bounded so a stuck output cannot hang the run.
    task automatic count_nmi(output int k);
        k = 0;
        while (NMI2 && k < 200) begin k++; cyc(); end
    endtask

    task automatic count_rst(output int k);
        k = 0;
        while (RSTSUB && k < 200) begin k++; cyc(); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v, e;
        int   k;
        bit   stayed;

        RST = 1'b1; LINE_STB = 1'b0; VPOS = '0; PAUSE = 1'b0; LWR = 1'b0;
        LAD = '0; LDI = 1'b0; ACK0 = 1'b0; ACK1 = 1'b0; NMIACK2 = 1'b0;
        #1;
        chk("rst_irq0", IRQ0, 0);
        chk("rst_irq1", IRQ1, 0);
        chk("rst_nmi2", NMI2, 0);
        chk("rst_rstsub", RSTSUB, 1);
        chk("rst_latch", LATCH, 8'h00);
        cyc(); cyc();
        RST = 1'b0;

        //            lwr  lad  ldi  stb  vpos  ack0  irq0  latch  rst
        tbl[0]  = '{1'b1, 3'd0, 1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 8'h01, 1'b1};
        tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b1, 9'd224, 1'b0, 1'b1, 8'h01, 1'b1};
        tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b1, 8'h01, 1'b1};
        tbl[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 8'h01, 1'b1};
        tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, 9'd100, 1'b0, 1'b0, 8'h01, 1'b1};
        tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b1, 9'd224, 1'b0, 1'b1, 8'h01, 1'b1};
        tbl[6]  = '{1'b0, 3'd0, 1'b0, 1'b1, 9'd224, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 9'd0,   1'b1, 1'b0, 8'h01, 1'b1};
        tbl[8]  = '{1'b1, 3'd0, 1'b0, 1'b1, 9'd224, 1'b0, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b1, 9'd224, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 3'd7, 1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 8'h80, 1'b1};
        tbl[12] = '{1'b1, 3'd5, 1'b1, 1'b0, 9'd0,   1'b0, 1'b0, 8'ha0, 1'b1};
        tbl[13] = '{1'b1, 3'd7, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 8'h20, 1'b1};
        tbl[14] = '{1'b1, 3'd5, 1'b0, 1'b0, 9'd0,   1'b0, 1'b0, 8'h00, 1'b1};

        for (int i = 0; i < 15; i++) begin
            v = tbl[i];
            LWR = v.lwr; LAD = v.lad; LDI = v.ldi;
            LINE_STB = v.stb; VPOS = v.vpos; ACK0 = v.ack0;
            sb_q.push_back(v);
            cyc();
            e = sb_q.pop_front();
            chk($sformatf("vec%0d_irq0", i), IRQ0, e.e_irq0);
            chk($sformatf("vec%0d_latch", i), LATCH, e.e_latch);
            chk($sformatf("vec%0d_rstsub", i), RSTSUB, e.e_rst);
        end
        LWR = 1'b0; LINE_STB = 1'b0; ACK0 = 1'b0;

        // Sub release: 1 + RST_HOLD cycles after the write edge.
        wr(3, 1'b1);
        count_rst(k);
        chk("release_delay", k, 17);

        // Withdraw release mid-countdown; hold must persist.
        wr(3, 1'b0);
        chk("rehold_rstsub", RSTSUB, 1);
        wr(3, 1'b1);
        repeat (4) cyc();
        wr(3, 1'b0);
        stayed = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!RSTSUB) stayed = 1'b0;
            cyc();
        end
        chk("abort_hold", stayed, 1);
        wr(3, 1'b1);
        count_rst(k);
        chk("release_again", k, 17);

        // IRQ1 set, then cleared by disabling its latch bit.
        wr(1, 1'b1);
        stb(224);
        chk("irq1_set", IRQ1, 1);
        wr(1, 1'b0);
        chk("irq1_latch_clr", IRQ1, 0);

        // Two NMI pulses of full width, then an early acknowledge.
        stb(64);
        chk("nmi_line0", NMI2, 1);
        count_nmi(k);
        chk("nmi_width0", k, 32);
        stb(192);
        count_nmi(k);
        chk("nmi_width1", k, 32);
        stb(64);
        repeat (9) cyc();
        chk("nmi_before_ack", NMI2, 1);
        NMIACK2 = 1'b1;
        cyc();
        NMIACK2 = 1'b0;
        chk("nmi_ack", NMI2, 0);

        // Events during pause are deferred and collapse to one each.
        wr(0, 1'b1);
        wr(1, 1'b1);
        PAUSE = 1'b1;
        stb(224); stb(64); stb(224); stb(192);
        repeat (3) cyc();
        chk("pause_irq0", IRQ0, 0);
        chk("pause_irq1", IRQ1, 0);
        chk("pause_nmi2", NMI2, 0);
        PAUSE = 1'b0;
        cyc();
        chk("unpause_irq0", IRQ0, 1);
        chk("unpause_irq1", IRQ1, 1);
        chk("unpause_nmi2", NMI2, 1);
        count_nmi(k);
        chk("unpause_nmi_width", k, 32);
        ACK0 = 1'b1;
        cyc();
        ACK0 = 1'b0;
        chk("unpause_ack0", IRQ0, 0);
        repeat (5) cyc();
        chk("unpause_once_irq0", IRQ0, 0);
        chk("unpause_once_nmi2", NMI2, 0);

        // Asynchronous reset mid-pulse with IRQ1 pending.
        stb(64);
        repeat (3) cyc();
        chk("pre_rst_nmi2", NMI2, 1);
        chk("pre_rst_irq1", IRQ1, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_irq0", IRQ0, 0);
        chk("async_irq1", IRQ1, 0);
        chk("async_nmi2", NMI2, 0);
        chk("async_rstsub", RSTSUB, 1);
        chk("async_latch", LATCH, 8'h00);
        cyc(); cyc();
        RST = 1'b0;
        cyc();
        chk("post_rst_rstsub", RSTSUB, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_irq_sched.md
# cpu_irq_sched

Interrupt and reset scheduler for the three Z80 cores in the DigDug CPU subsystem. Owns the 8-bit misc-control latch (CPU address 0x6820-0x6827, one data bit per address). Generates the per-frame maskable IRQs for the main and sub CPU and the twice-per-frame NMI for the sound CPU, and sequences the shared reset of the sub and sound CPUs. Sits between the video timing generator, the CPU address decode and the CPU cores' IRQ/NMI/RESET inputs.

## Interface
- IRQ_LINE, 224: scanline on which IRQ0/IRQ1 are raised.
- NMI_LINE0, 64: first NMI scanline for CPU2.
- NMI_LINE1, 192: second NMI scanline for CPU2.
- NMI_WIDTH, 32: NMI2 pulse length in CLK cycles (1..255).
- RST_HOLD, 16: extra CLK cycles RSTSUB stays high after release (0..255).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  reset: RST, asynchronous, active-high.
- LINE_STB  in  1  one-CLK pulse at the start of each scanline.
- VPOS  in  9  current scanline, valid when LINE_STB=1.
- PAUSE  in  1  global pause; defers new interrupt events.
- LWR  in  1  one-CLK latch write strobe.
- LAD  in  3  latch bit select.
- LDI  in  1  latch write data.
- ACK0  in  1  CPU0 interrupt-acknowledge pulse.
- ACK1  in  1  CPU1 interrupt-acknowledge pulse.
- NMIACK2  in  1  CPU2 fetch from 0x0066.
- IRQ0  out  1  IRQ to CPU0, active-high.
- IRQ1  out  1  IRQ to CPU1, active-high.
- NMI2  out  1  NMI to CPU2, active-high.
- RSTSUB  out  1  reset to CPU1 and CPU2, active-high.
- LATCH  out  8  current latch contents.

## Operation
- Latch: LWR=1 writes LDI into LATCH[LAD] on the next edge; the remaining bits are unchanged. Reset value is 8'h00.
  - bit0: IRQ0 enable.
  - bit1: IRQ1 enable.
  - bit2: NMI2 disable (1 = disabled).
  - bit3: sub release (0 = hold CPU1/CPU2 in reset).
  - bits 7:4: passthrough, observable only on LATCH.
- Events are qualified on LINE_STB.
  - E_IRQ when VPOS==IRQ_LINE.
  - E_NMI when VPOS==NMI_LINE0 or VPOS==NMI_LINE1.
- PAUSE=1: events set sticky pending flags (pIRQ, pNMI) instead of acting. The first cycle with PAUSE=0 applies them once and clears them. Multiple events during a pause collapse to one. Outputs already asserted keep their state during PAUSE.
- IRQ0 behaviour:
  - Set on E_IRQ (or pending) when LATCH[0]=1.
  - Cleared on ACK0, or on the edge LATCH[0] becomes 0.
  - Level, no timeout.
- IRQ1: same rules using LATCH[1] and ACK1. Additionally forced 0 while RSTSUB=1.
- NMI2 FSM with states N_IDLE and N_PULSE, plus an 8-bit down counter.
  - N_IDLE -> N_PULSE on E_NMI (or pending) when LATCH[2]=0 and RSTSUB=0. Loads counter with NMI_WIDTH-1; NMI2=1.
  - N_PULSE -> N_IDLE when counter==0, or NMIACK2=1, or LATCH[2] becomes 1, or RSTSUB=1. NMI2=0.
  - E_NMI while in N_PULSE reloads the counter (retrigger).
- Sub reset FSM with states S_HOLD, S_REL_WAIT and S_RUN, plus an 8-bit counter.
  - S_HOLD: RSTSUB=1. Goes to S_REL_WAIT when LATCH[3]=1 and loads the counter with RST_HOLD.
  - S_REL_WAIT: RSTSUB=1. Decrements; goes to S_RUN when counter==0. If LATCH[3] returns to 0, goes back to S_HOLD.
  - S_RUN: RSTSUB=0. Goes to S_HOLD on the edge LATCH[3] becomes 0.
- Simultaneous events:
  - Set and ack/clear in the same cycle: set wins, output stays 1.
  - Latch write and event in the same cycle: the event uses the old latch value.

## Timing
- All outputs are registered.
- Reset values: IRQ0=0, IRQ1=0, NMI2=0, RSTSUB=1, LATCH=8'h00. FSMs reset to N_IDLE and S_HOLD; pending flags clear.
- RST asserted mid-operation aborts any pulse or hold countdown immediately (asynchronous).
- E_IRQ/E_NMI at edge n gives the output at 1 after edge n (1-cycle latency).
- ACK0/ACK1/NMIACK2 at edge n gives the output at 0 after edge n.
- NMI2 high width with no early clear is exactly NMI_WIDTH cycles.
- Release: LATCH[3] written to 1 at edge n gives RSTSUB=0 after edge n+1+RST_HOLD. With RST_HOLD=0 that is edge n+1.
- PAUSE falling at edge n: pending events apply at edge n+1.

## Test plan
- Reset, then write LATCH[0]=1 and pulse LINE_STB at VPOS=224 -> IRQ0=1 one cycle later; ACK0 pulse -> IRQ0=0 next cycle. LATCH reads 8'h01.
- LATCH[3]=1 with RST_HOLD=16 -> RSTSUB falls exactly 17 cycles after the write edge. Write LATCH[3]=0 at cycle 5 of the hold -> RSTSUB stays 1 and the FSM returns to S_HOLD.
- Sub running, LATCH[2]=0, LINE_STB at VPOS=64 and 192 -> two NMI2 pulses, each 32 cycles. NMIACK2 at cycle 10 of a pulse -> NMI2=0 next cycle.
- PAUSE=1 across VPOS=224 and 64 strobes, then PAUSE=0 -> IRQ0 and NMI2 assert one cycle after PAUSE falls, once each.
- ACK0 in the same cycle as a new E_IRQ -> IRQ0 remains 1. LATCH[1] cleared while IRQ1=1 -> IRQ1=0 next cycle.
- Assert RST during an NMI2 pulse and an IRQ1 -> all outputs at reset values with no clock edge required.
